// File: rtl/plab4_net_router_adaptive_input_terminal_ctrl_wh_pkg.sv
// Shared route encoding for the adaptive wormhole input-terminal controller.
// Imported by the controller and its ring route-compute helper.
package plab4_net_router_adaptive_input_terminal_ctrl_wh_pkg;

    localparam int ROUTE_NBITS = 2;

    localparam logic [ROUTE_NBITS-1:0] ROUTE_PREV = 2'd0;
    localparam logic [ROUTE_NBITS-1:0] ROUTE_TERM = 2'd1;
    localparam logic [ROUTE_NBITS-1:0] ROUTE_NEXT = 2'd2;

    function automatic logic [ROUTE_NBITS-1:0] opposite_dir(
        input logic [ROUTE_NBITS-1:0] r
    );
        return (r == ROUTE_PREV) ? ROUTE_NEXT : ROUTE_PREV;
    endfunction

endpackage

// File: rtl/plab4_net_router_adaptive_route_compute_ring.sv
// Combinational minimal/adaptive ring route: shortest direction, ties broken
// toward the channel with more free slots (exact tie goes NEXT).
module plab4_net_router_adaptive_route_compute_ring
    import plab4_net_router_adaptive_input_terminal_ctrl_wh_pkg::*;
#(
    parameter int p_router_id           = 0,
    parameter int p_num_routers         = 8,
    parameter int p_num_free_chan_nbits = 2,
    parameter int c_dest_nbits          = $clog2(p_num_routers)
)(
    input  logic [c_dest_nbits-1:0]          dest,
    input  logic [p_num_free_chan_nbits-1:0] num_free_chan0,
    input  logic [p_num_free_chan_nbits-1:0] num_free_chan2,
    output logic [ROUTE_NBITS-1:0]           route
);

    localparam int c_w = c_dest_nbits + 1;
    localparam logic [c_w-1:0] c_id = c_w'(p_router_id);
    localparam logic [c_w-1:0] c_n  = c_w'(p_num_routers);

    logic [c_w-1:0] dext;
    logic [c_w-1:0] dn;
    logic [c_w-1:0] dp;

    assign dext = {1'b0, dest};

    // dn: hops going next, dp: hops going prev
    always_comb begin
        dn = '0;
        if (dext >= c_id)
            dn = dext - c_id;
        else
            dn = dext + c_n - c_id;
        dp = c_n - dn;
    end

    always_comb begin
        route = ROUTE_TERM;
        if (dext == c_id)
            route = ROUTE_TERM;
        else if (dn < dp)
            route = ROUTE_NEXT;
        else if (dp < dn)
            route = ROUTE_PREV;
        else if (num_free_chan2 > num_free_chan0)
            route = ROUTE_PREV;
        else
            route = ROUTE_NEXT;
    end

endmodule

// File: rtl/plab4_net_router_adaptive_input_terminal_ctrl_wh.sv
// Wormhole input-terminal controller: adaptive head routing, per-packet port lock.
// Optional starvation escape compiled in with PLAB4_NET_STARVE_ESCAPE_EN.
module plab4_net_router_adaptive_input_terminal_ctrl_wh
    import plab4_net_router_adaptive_input_terminal_ctrl_wh_pkg::*;
#(
    parameter int p_router_id           = 0,
    parameter int p_num_routers         = 8,
    parameter int p_num_free_nbits      = 2,
    parameter int p_num_free_chan_nbits = 2,
    parameter int p_head_min_free       = 2,
    parameter int p_body_min_free       = 1,
    parameter int p_starve_limit        = 16,
    parameter int p_num_domains         = 2,
    parameter int c_dest_nbits          = $clog2(p_num_routers),
    parameter int c_dom_nbits           = (p_num_domains > 1) ? $clog2(p_num_domains) : 1,
    parameter int c_starve_nbits        = $clog2(p_starve_limit + 1)
)(
    input  logic                             clk,
    input  logic                             reset,
    input  logic [c_dest_nbits-1:0]          dest,
    input  logic                             in_val,
    output logic                             in_rdy,
    input  logic                             in_head,
    input  logic                             in_tail,
    input  logic [p_num_free_nbits-1:0]      num_free0,
    input  logic [p_num_free_nbits-1:0]      num_free2,
    input  logic [p_num_free_chan_nbits-1:0] num_free_chan0,
    input  logic [p_num_free_chan_nbits-1:0] num_free_chan2,
    output logic                             reqs_p0,
    output logic                             reqs_p1,
    output logic                             reqs_p2,
    input  logic                             grants_p0,
    input  logic                             grants_p1,
    input  logic                             grants_p2,
    output logic [c_dom_nbits-1:0]           domain,
    output logic                             route_locked
);

    typedef enum logic {IDLE, LOCKED} state_t;

    state_t                 state;
    logic [ROUTE_NBITS-1:0] route_q;
    logic [ROUTE_NBITS-1:0] route_c;
    logic [ROUTE_NBITS-1:0] route_sel;
    logic                   prev_head_ok;
    logic                   next_head_ok;
    logic                   prev_body_ok;
    logic                   next_body_ok;
    logic                   port_ok;
    logic                   req_en;
    logic                   unused_head;

    assign domain      = c_dom_nbits'(p_router_id % p_num_domains);
    assign unused_head = in_head;

    plab4_net_router_adaptive_route_compute_ring #(
        .p_router_id           (p_router_id),
        .p_num_routers         (p_num_routers),
        .p_num_free_chan_nbits (p_num_free_chan_nbits),
        .c_dest_nbits          (c_dest_nbits)
    ) route_compute (
        .dest           (dest),
        .num_free_chan0 (num_free_chan0),
        .num_free_chan2 (num_free_chan2),
        .route          (route_c)
    );

    // num_free0 tracks the next buffer, num_free2 the prev buffer
    assign next_head_ok = int'(num_free0) >= p_head_min_free;
    assign prev_head_ok = int'(num_free2) >= p_head_min_free;
    assign next_body_ok = int'(num_free0) >= p_body_min_free;
    assign prev_body_ok = int'(num_free2) >= p_body_min_free;

`ifdef PLAB4_NET_STARVE_ESCAPE_EN
    localparam logic [c_starve_nbits-1:0] c_starve_lim =
        c_starve_nbits'(p_starve_limit);

    logic [c_starve_nbits-1:0] starve_cnt;
    logic                      min_blocked;
    logic                      alt_ok;

    always_comb begin
        min_blocked = 1'b0;
        alt_ok      = 1'b0;
        if (route_c == ROUTE_NEXT) begin
            min_blocked = !next_head_ok;
            alt_ok      = prev_head_ok;
        end else if (route_c == ROUTE_PREV) begin
            min_blocked = !prev_head_ok;
            alt_ok      = next_head_ok;
        end
    end

    always_comb begin
        route_sel = route_c;
        if (starve_cnt >= c_starve_lim && min_blocked && alt_ok)
            route_sel = opposite_dir(route_c);
        if (state == LOCKED)
            route_sel = route_q;
    end

    always_ff @(posedge clk) begin
        if (reset)
            starve_cnt <= '0;
        else if (!in_val || in_rdy)
            starve_cnt <= '0;
        else if (state == IDLE && starve_cnt < c_starve_lim)
            starve_cnt <= starve_cnt + 1'b1;
    end
`else
    logic [c_starve_nbits-1:0] unused_starve;
    assign unused_starve = '0;

    always_comb begin
        route_sel = route_c;
        if (state == LOCKED)
            route_sel = route_q;
    end
`endif

    // Heads need the larger bubble margin; body/tail flits only the smaller one
    always_comb begin
        port_ok = 1'b0;
        unique case (route_sel)
            ROUTE_TERM: port_ok = 1'b1;
            ROUTE_PREV: port_ok = (state == LOCKED) ? prev_body_ok : prev_head_ok;
            ROUTE_NEXT: port_ok = (state == LOCKED) ? next_body_ok : next_head_ok;
            default:    port_ok = 1'b0;
        endcase
    end

    assign req_en  = !reset && in_val && port_ok;
    assign reqs_p0 = req_en && (route_sel == ROUTE_PREV);
    assign reqs_p1 = req_en && (route_sel == ROUTE_TERM);
    assign reqs_p2 = req_en && (route_sel == ROUTE_NEXT);

    assign in_rdy = (reqs_p0 && grants_p0)
                 || (reqs_p1 && grants_p1)
                 || (reqs_p2 && grants_p2);

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            route_q      <= ROUTE_TERM;
            route_locked <= 1'b0;
        end else if (in_rdy) begin
            case (state)
                IDLE: begin
                    if (!in_tail) begin
                        state        <= LOCKED;
                        route_q      <= route_sel;
                        route_locked <= 1'b1;
                    end
                end
                LOCKED: begin
                    if (in_tail) begin
                        state        <= IDLE;
                        route_locked <= 1'b0;
                    end
                end
                default: begin
                    state        <= IDLE;
                    route_locked <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_plab4_net_router_adaptive_input_terminal_ctrl_wh.sv
// Scoreboard bench: stimulus pushes reference-model expectations, a negedge
// monitor pops and compares reqs / in_rdy / route_locked each cycle.
module tb_plab4_net_router_adaptive_input_terminal_ctrl_wh;

    localparam int ID    = 0;
    localparam int N     = 8;
    localparam int HMIN  = 2;
    localparam int BMIN  = 1;
    localparam int SLIM  = 4;
    localparam int NDOM  = 2;

    typedef struct {
        logic [2:0] reqs;
        logic       rdy;
        logic       lk;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset;
    logic [2:0] dest;
    logic       in_val, in_rdy, in_head, in_tail;
    logic [1:0] num_free0, num_free2, num_free_chan0, num_free_chan2;
    logic       reqs_p0, reqs_p1, reqs_p2;
    logic       grants_p0, grants_p1, grants_p2;
    logic [0:0] domain;
    logic       route_locked;

    exp_t q[$];
    int   n_cmp  = 0;
    int   n_fail = 0;

    bit m_locked = 0;
    int m_route  = 1;
    int m_cnt    = 0;

    always #5 clk = ~clk;

    plab4_net_router_adaptive_input_terminal_ctrl_wh #(
        .p_router_id    (ID),
        .p_num_routers  (N),
        .p_head_min_free(HMIN),
        .p_body_min_free(BMIN),
        .p_starve_limit (SLIM),
        .p_num_domains  (NDOM)
    ) dut (
        .clk(clk), .reset(reset), .dest(dest),
        .in_val(in_val), .in_rdy(in_rdy),
        .in_head(in_head), .in_tail(in_tail),
        .num_free0(num_free0), .num_free2(num_free2),
        .num_free_chan0(num_free_chan0), .num_free_chan2(num_free_chan2),
        .reqs_p0(reqs_p0), .reqs_p1(reqs_p1), .reqs_p2(reqs_p2),
        .grants_p0(grants_p0), .grants_p1(grants_p1), .grants_p2(grants_p2),
        .domain(domain), .route_locked(route_locked)
    );

    // 0=prev, 1=term, 2=next by shortest hop count on the ring
    function automatic int route_ref(input int d, input int c0, input int c2);
        int fwd, bwd;
        if (d == ID) return 1;
        fwd = (d - ID + N) % N;
        bwd = N - fwd;
        if (fwd < bwd) return 2;
        if (bwd < fwd) return 0;
        return (c2 > c0) ? 0 : 2;
    endfunction

    function automatic int free_of(input int r, input int f0, input int f2);
        return (r == 0) ? f2 : f0;
    endfunction

    task automatic step(input bit rst, input bit val, input bit tl,
                        input int d, input int f0, input int f2,
                        input int c0, input int c2, input bit [2:0] g);
        int   r, thr;
        bit   ok;
        exp_t e;
        @(posedge clk);
        #1;
        reset = rst; in_val = val; in_tail = tl;
        in_head = 1'($urandom_range(0, 1));
        dest = 3'(d);
        num_free0 = 2'(f0); num_free2 = 2'(f2);
        num_free_chan0 = 2'(c0); num_free_chan2 = 2'(c2);
        {grants_p2, grants_p1, grants_p0} = g;
        if (m_locked) begin
            r = m_route;
        end else begin
            r = route_ref(d, c0, c2);
`ifdef PLAB4_NET_STARVE_ESCAPE_EN
            if (m_cnt >= SLIM && r != 1 && free_of(r, f0, f2) < HMIN
                && free_of(2 - r, f0, f2) >= HMIN)
                r = 2 - r;
`endif
        end
        thr = m_locked ? BMIN : HMIN;
        ok  = (r == 1) || (free_of(r, f0, f2) >= thr);
        e.reqs = (!rst && val && ok) ? 3'(1 << r) : 3'b000;
        e.rdy  = |(e.reqs & g);
        e.lk   = m_locked;
        q.push_back(e);
        if (rst) begin
            m_locked = 0;
            m_route  = 1;
            m_cnt    = 0;
        end else begin
            if (!val || e.rdy) m_cnt = 0;
            else if (!m_locked && m_cnt < SLIM) m_cnt++;
            if (e.rdy) begin
                if (!m_locked && !tl) begin
                    m_locked = 1;
                    m_route  = r;
                end else if (m_locked && tl) begin
                    m_locked = 0;
                end
            end
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() != 0) begin
                e = q.pop_front();
                n_cmp++;
                if ({reqs_p2, reqs_p1, reqs_p0} !== e.reqs) begin
                    n_fail++;
                    $display("FAIL reqs t=%0t got=%b exp=%b", $time,
                             {reqs_p2, reqs_p1, reqs_p0}, e.reqs);
                end
                n_cmp++;
                if (in_rdy !== e.rdy) begin
                    n_fail++;
                    $display("FAIL in_rdy t=%0t got=%b exp=%b", $time, in_rdy, e.rdy);
                end
                n_cmp++;
                if (route_locked !== e.lk) begin
                    n_fail++;
                    $display("FAIL route_locked t=%0t got=%b exp=%b", $time,
                             route_locked, e.lk);
                end
            end
        end
    end

    initial begin : stim
        reset = 1; in_val = 0; in_head = 0; in_tail = 0; dest = '0;
        num_free0 = 0; num_free2 = 0; num_free_chan0 = 0; num_free_chan2 = 0;
        {grants_p2, grants_p1, grants_p0} = 3'b000;
        repeat (2) @(posedge clk);

        // reset held with traffic offered
        step(1, 1, 0, 2, 3, 3, 0, 0, 3'b111);
        // single-flit local packet
        step(0, 1, 1, 0, 0, 0, 0, 0, 3'b010);
        step(0, 1, 1, 0, 0, 0, 0, 0, 3'b010);
        // three-flit packet heading next
        step(0, 1, 0, 2, 2, 0, 0, 0, 3'b111);
        step(0, 1, 0, 5, 2, 0, 0, 0, 3'b111);
        step(0, 1, 1, 6, 2, 0, 0, 0, 3'b111);
        // head blocked by bubble rule, then body passes at lower margin
        step(0, 1, 0, 2, 1, 3, 0, 0, 3'b111);
        step(0, 1, 0, 2, 2, 3, 0, 0, 3'b111);
        step(0, 1, 0, 2, 1, 0, 0, 0, 3'b111);
        step(0, 1, 1, 2, 1, 0, 0, 0, 3'b111);
        // equidistant destination: channel counts decide
        step(0, 1, 0, 4, 3, 3, 1, 3, 3'b000);
        step(0, 1, 0, 4, 3, 3, 2, 2, 3'b000);
        step(0, 0, 0, 4, 3, 3, 2, 2, 3'b000);
        // starved head toward next, prev has room
        for (int i = 0; i < 6; i++)
            step(0, 1, 0, 1, 0, 3, 0, 0, 3'b000);
        step(0, 1, 0, 1, 0, 3, 0, 0, 3'b111);
        step(0, 1, 1, 1, 3, 3, 0, 0, 3'b111);
        // reset in the middle of a locked packet
        step(0, 1, 0, 2, 3, 3, 0, 0, 3'b111);
        step(0, 1, 0, 2, 3, 3, 0, 0, 3'b111);
        step(1, 1, 0, 2, 3, 3, 0, 0, 3'b111);
        step(1, 1, 1, 0, 3, 3, 0, 0, 3'b111);
        step(0, 1, 1, 0, 3, 3, 0, 0, 3'b010);

        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 99) == 0,
                 $urandom_range(0, 3) != 0,
                 $urandom_range(0, 2) == 0,
                 int'($urandom_range(0, N - 1)),
                 int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                 int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                 3'($urandom_range(0, 7)));
        end

        @(posedge clk);
        repeat (3) @(negedge clk);
        n_cmp++;
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL drain left=%0d exp=0", q.size());
        end
        n_cmp++;
        if (domain !== 1'(ID % NDOM)) begin
            n_fail++;
            $display("FAIL domain got=%0d exp=%0d", domain, ID % NDOM);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
